// File: rtl/oven_timer_ctrl.sv
// Microwave oven countdown controller: BCD keypad entry, cook/pause
// countdown on the 1 Hz tick, and a tick-limited alarm when time runs out.
module oven_timer_ctrl #(
  parameter int ALARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] digit_in,
  input  logic       key,
  input  logic       start,
  input  logic       cancel,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heater_on,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [CW:0] ALARM_LAST = (CW + 1)'(ALARM_TICKS);

  state_t        st;
  logic          key_q;
  logic [CW-1:0] acnt;
  logic          key_edge;
  logic          digit_ok;
  logic          time_zero;
  logic          time_one;
  logic          alarm_end;

  assign key_edge  = key & ~key_q;
  assign digit_ok  = (digit_in <= 4'd9);
  assign time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
  assign time_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
  assign alarm_end = (({1'b0, acnt} + 1'b1) == ALARM_LAST);

  assign state     = st;
  assign heater_on = (st == COOK);
  assign alarm     = (st == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      key_q    <= 1'b0;
      acnt     <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      key_q <= key;
      unique case (st)
        IDLE: begin
          if (cancel) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start && !door_open && !time_zero) begin
            st <= COOK;
          end else if (key_edge && digit_ok) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= digit_in;
          end
        end
        COOK: begin
          if (cancel) begin
            st       <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (door_open) begin
            st <= PAUSE;
          end else if (tick) begin
            if (time_one) begin
              st       <= DONE;
              sec_ones <= 4'd0;
              acnt     <= '0;
            end else if (sec_ones != 4'd0) begin
              sec_ones <= sec_ones - 4'd1;
            end else if (sec_tens != 4'd0) begin
              sec_tens <= sec_tens - 4'd1;
              sec_ones <= 4'd9;
            end else begin
              // seconds exhausted: borrow a minute
              sec_tens <= 4'd5;
              sec_ones <= 4'd9;
              if (min_ones != 4'd0) begin
                min_ones <= min_ones - 4'd1;
              end else begin
                min_ones <= 4'd9;
                min_tens <= min_tens - 4'd1;
              end
            end
          end
        end
        PAUSE: begin
          if (cancel) begin
            st       <= IDLE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start && !door_open) begin
            st <= COOK;
          end
        end
        DONE: begin
          if (cancel || door_open || key_edge) begin
            st <= IDLE;
          end else if (tick) begin
            if (alarm_end) st <= IDLE;
            else acnt <= acnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/oven_timer_ctrl.md
OVEN_TIMER_CTRL -- requirements
Module: oven_timer_ctrl

Interface
REQ-001 The block SHALL have parameter ALARM_TICKS, default 3, giving the number of tick pulses the alarm stays asserted in DONE.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port tick, input, 1, one-clk-wide 1 Hz enable from the seconds divider.
REQ-005 The block SHALL have port digit_in, input, 4, BCD keypad digit value.
REQ-006 The block SHALL have port key, input, 1, synchronous push-button level; digit entry on its rising edge.
REQ-007 The block SHALL have port start, input, 1, synchronous level start/resume request.
REQ-008 The block SHALL have port cancel, input, 1, synchronous level cancel/clear request.
REQ-009 The block SHALL have port door_open, input, 1, high while the oven door is open.
REQ-010 The block SHALL have outputs min_tens, min_ones, sec_tens, sec_ones, each 4 bits, BCD remaining-time digits for the seven-segment decoders.
REQ-011 The block SHALL have output heater_on, 1 bit, high exactly while state is COOK.
REQ-012 The block SHALL have output alarm, 1 bit, high exactly while state is DONE.
REQ-013 The block SHALL have output state, 2 bits, encoded IDLE=0, COOK=1, PAUSE=2, DONE=3.

Function
REQ-014 The block SHALL register key each clk and detect a key edge as key=1 while the previous sample was 0.
REQ-015 In IDLE, a key edge with digit_in <= 9 SHALL shift the time left one digit on that edge: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in.
REQ-016 A key edge with digit_in > 9, or any key edge outside IDLE, SHALL be ignored; the edge register still updates.
REQ-017 sec_tens SHALL be allowed to hold 6-9 after entry; entry 0:90 counts 90 s total.
REQ-018 In IDLE, start=1 with door_open=0 and nonzero time SHALL move to COOK on the next edge; start with time 00:00 or door open SHALL be ignored.
REQ-019 In COOK, each tick SHALL decrement the time by one second in BCD: sec_ones 0 borrows from sec_tens; seconds 00 with nonzero minutes reload to 59 and decrement minutes with min_ones borrowing from min_tens.
REQ-020 A tick that takes time from 00:01 to 00:00 SHALL move to DONE on that same edge.
REQ-021 In COOK, door_open=1 SHALL move to PAUSE on the next edge, with the time unchanged even if tick is high that cycle.
REQ-022 In PAUSE, the time SHALL hold; start=1 with door_open=0 SHALL return to COOK on the next edge.
REQ-023 In COOK or PAUSE, cancel=1 SHALL move to IDLE and clear all four digits to 0 on the next edge.
REQ-024 In IDLE, cancel=1 SHALL clear all four digits to 0.
REQ-025 Cancel SHALL have priority over door_open, and door_open SHALL have priority over start and tick.
REQ-026 On entry to DONE, an alarm tick counter SHALL load 0; each tick in DONE SHALL increment it.
REQ-027 DONE SHALL move to IDLE on the edge where the counter reaches ALARM_TICKS, or on the next edge when cancel, door_open, or a key edge occurs.
REQ-028 In DONE, digits SHALL read 00:00.
REQ-029 heater_on and alarm SHALL be decoded combinationally from the state register, with no extra latency.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force state=IDLE, all digits to 0, the key-edge register to 0 and the alarm counter to 0, giving heater_on=0 and alarm=0.
REQ-031 Reset asserted during COOK SHALL abort the cook immediately; after release the block SHALL accept entry in IDLE.

Verification
REQ-032 Entry: key edges with digits 1, 3, 0 -> time 01:30; key edge with digit_in=12 -> time stays 01:30.
REQ-033 Countdown: 01:00, start, then 1 tick -> 00:59 with heater_on=1; after 60 ticks total -> DONE, alarm=1, 00:00.
REQ-034 Borrow: 10:00 -> one tick -> 09:59; entry 0:90 -> 90 ticks -> DONE.
REQ-035 Door: COOK at 00:30, door_open=1 and tick in the same cycle -> PAUSE at 00:30, heater_on=0; door closed and start -> COOK, next tick 00:29.
REQ-036 Alarm: with ALARM_TICKS=3, in DONE -> 3 ticks -> IDLE; key edge after 1 tick -> IDLE on the next edge.
REQ-037 Priority/reset: start with 00:00 -> stays IDLE; cancel and start together in PAUSE -> IDLE, 00:00; reset mid-COOK -> IDLE, 00:00, heater_on=0 with no clk edge.
